// File: rtl/rs_enc_stream.sv
// Systematic Reed-Solomon encoder with a sop/eop/val/ena streaming interface.
// Data symbols pass straight through; CHECK parity symbols follow each block.
module rs_enc_stream #(
    parameter int unsigned M         = 8,
    parameter int unsigned CHECK     = 16,
    parameter int unsigned IRRPOL    = 285,
    parameter int unsigned GENSTART  = 0,
    parameter int unsigned ROOTSPACE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_sink_val,
    input  logic         i_sink_sop,
    input  logic         i_sink_eop,
    output logic         o_sink_ena,
    input  logic [M-1:0] i_rsin,
    input  logic         i_source_ena,
    output logic         o_source_val,
    output logic         o_source_sop,
    output logic         o_source_eop,
    output logic [M-1:0] o_rsout,
    output logic         o_err
);

    localparam logic [M:0]  IRR    = IRRPOL[M:0];
    localparam int unsigned NFIELD = (1 << M) - 1;
    localparam logic [M:0]  KMAX   = (M+1)'(NFIELD - CHECK);
    localparam int unsigned PW     = $clog2(CHECK);

    typedef logic [CHECK-1:0][M-1:0] poly_t;
    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M:0] p;
        p = '0;
        for (int k = M - 1; k >= 0; k--) begin
            p = p << 1;
            if (p[M]) p = p ^ IRR;
            if (b[k]) p = p ^ {1'b0, a};
        end
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int unsigned e);
        logic [M-1:0] x;
        x = M'(1);
        for (int unsigned n = 0; n < (e % NFIELD); n++) x = gf_mul(x, M'(2));
        return x;
    endfunction

    // Monic generator; the implicit x^CHECK coefficient is not stored.
    function automatic poly_t gen_poly();
        logic [CHECK:0][M-1:0] g;
        logic [M-1:0]          root;
        g    = '0;
        g[0] = M'(1);
        for (int i = 0; i < CHECK; i++) begin
            root = alpha_pow(ROOTSPACE * (GENSTART + unsigned'(i)));
            for (int j = CHECK; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
        end
        return g[CHECK-1:0];
    endfunction

    localparam poly_t GEN = gen_poly();

    state_e          r_state;
    poly_t           r_lfsr;
    logic [M:0]      r_cnt;
    logic [PW-1:0]   r_par_cnt;
    logic            r_source_val;
    logic            r_source_sop;
    logic            r_source_eop;
    logic [M-1:0]    r_rsout;
    logic            r_err;

    logic            w_adv;
    logic            w_acc;
    poly_t           w_lfsr_base;
    poly_t           w_lfsr_upd;
    logic [M-1:0]    w_fb;
    logic [M:0]      w_cnt_base;
    logic [M:0]      w_cnt_new;
    logic            w_cnt_sat;
    logic            w_cnt_ovf;

    assign w_adv      = !r_source_val || i_source_ena;
    assign o_sink_ena = i_rst_n && w_adv && (r_state != StParity);
    assign w_acc      = i_sink_val && o_sink_ena;

    // A sop always starts from a cleared remainder and counter.
    assign w_lfsr_base = i_sink_sop ? '0 : r_lfsr;
    assign w_fb        = i_rsin ^ w_lfsr_base[CHECK-1];
    assign w_cnt_base  = i_sink_sop ? '0 : r_cnt;
    assign w_cnt_sat   = w_cnt_base > KMAX;
    assign w_cnt_new   = w_cnt_sat ? w_cnt_base : w_cnt_base + (M+1)'(1);
    assign w_cnt_ovf   = !w_cnt_sat && (w_cnt_new > KMAX);

    always_comb begin
        w_lfsr_upd    = '0;
        w_lfsr_upd[0] = gf_mul(GEN[0], w_fb);
        for (int i = 1; i < CHECK; i++) begin
            w_lfsr_upd[i] = w_lfsr_base[i-1] ^ gf_mul(GEN[i], w_fb);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_lfsr       <= '0;
            r_cnt        <= '0;
            r_par_cnt    <= '0;
            r_source_val <= 1'b0;
            r_source_sop <= 1'b0;
            r_source_eop <= 1'b0;
            r_rsout      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            // Nothing moves while a presented symbol waits for downstream.
            if (w_adv) begin
                r_source_val <= 1'b0;
                r_source_sop <= 1'b0;
                r_source_eop <= 1'b0;
                case (r_state)
                    StIdle, StData: begin
                        if (w_acc) begin
                            if (i_sink_sop || r_state == StData) begin
                                r_source_val <= 1'b1;
                                r_source_sop <= i_sink_sop;
                                r_rsout      <= i_rsin;
                                r_lfsr       <= w_lfsr_upd;
                                r_cnt        <= w_cnt_new;
                                r_err        <= w_cnt_ovf || (i_sink_sop && r_state == StData);
                                r_state      <= i_sink_eop ? StParity : StData;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    StParity: begin
                        r_source_val <= 1'b1;
                        r_rsout      <= r_lfsr[CHECK-1];
                        r_lfsr       <= r_lfsr << M;
                        if (r_par_cnt == PW'(CHECK - 1)) begin
                            r_source_eop <= 1'b1;
                            r_state      <= StIdle;
                            r_par_cnt    <= '0;
                            r_cnt        <= '0;
                        end else begin
                            r_par_cnt <= r_par_cnt + PW'(1);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_source_val = r_source_val;
    assign o_source_sop = r_source_sop;
    assign o_source_eop = r_source_eop;
    assign o_rsout      = r_rsout;
    assign o_err        = r_err;

endmodule
